// File: rtl/instr_prefetch.sv
// Instruction prefetcher: req/gnt/rvalid bus initiator feeding a small {addr,word} FIFO to decode.
// Define INSTR_PREFETCH_PROTO_CHK_EN to build the protocol checker behind the sticky proto_err_o.
module instr_prefetch #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] boot_addr_i,
  input  logic        fetch_en_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_rvalid_i,
  output logic        proto_err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_e;
  state_e state_q, state_d;

  logic [31:0]   pc_q, pc_d, req_addr_q, req_addr_d;
  logic          kill_q, kill_d;
  logic [CW-1:0] out_q, out_d, discard_q, discard_d, cnt_q, cnt_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [IW-1:0] iwp_q, iwp_d, irp_q, irp_d;
  logic [31:0]   fdata_q [DEPTH];
  logic [31:0]   fdata_d [DEPTH];
  logic [31:0]   faddr_q [DEPTH];
  logic [31:0]   faddr_d [DEPTH];
  logic [31:0]   iaddr_q [MAX_OUTSTANDING];
  logic [31:0]   iaddr_d [MAX_OUTSTANDING];
  logic          gnt, rsp, drop, push, pop, can_issue, can_cont;

  function automatic logic [IW-1:0] iwrap(input logic [IW-1:0] p);
    return (p == IW'(MAX_OUTSTANDING - 1)) ? '0 : p + IW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Credit covers words in flight plus words buffered, so the FIFO can never overflow.
  assign can_issue = fetch_en_i && (out_q < CW'(MAX_OUTSTANDING)) &&
                     (({1'b0, out_q} + {1'b0, cnt_q}) < (CW+1)'(DEPTH));
  assign can_cont  = fetch_en_i && (out_d < CW'(MAX_OUTSTANDING)) &&
                     (({1'b0, out_d} + {1'b0, cnt_d}) < (CW+1)'(DEPTH));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, HOLD: state_d = can_issue ? REQ : (fetch_en_i ? HOLD : IDLE);
      REQ:        if (gnt) state_d = can_cont ? REQ : (fetch_en_i ? HOLD : IDLE);
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_req_o  = (state_q == REQ);
    instr_addr_o = req_addr_q;
  end

  assign gnt           = instr_req_o && instr_gnt_i;
  assign fetch_valid_o = (cnt_q != '0);
  assign fetch_rdata_o = fetch_valid_o ? fdata_q[rp_q] : '0;
  assign fetch_addr_o  = fetch_valid_o ? faddr_q[rp_q] : '0;

  always_comb begin
    rsp   = instr_rvalid_i && (out_q != '0);
    drop  = rsp && (discard_q != '0);
    push  = rsp && !drop && !branch_i;
    pop   = fetch_valid_o && fetch_ready_i && !branch_i;
    out_d = out_q + CW'(gnt) - CW'(rsp);

    // A request killed by a branch is still granted later; its word must be thrown away too.
    discard_d = discard_q;
    if (drop)            discard_d = discard_d - CW'(1);
    if (gnt && kill_q)   discard_d = discard_d + CW'(1);
    if (branch_i)        discard_d = out_d;

    kill_d = kill_q;
    if (gnt)                           kill_d = 1'b0;
    else if (branch_i && instr_req_o)  kill_d = 1'b1;

    pc_d = pc_q;
    if (gnt && !kill_q) pc_d = pc_q + 32'd4;
    if (branch_i)       pc_d = branch_addr_i & 32'hFFFF_FFFC;

    req_addr_d = req_addr_q;
    if (state_d == REQ && (state_q != REQ || gnt)) req_addr_d = pc_d;

    iwp_d   = iwp_q;
    irp_d   = irp_q;
    iaddr_d = iaddr_q;
    if (gnt) begin
      iaddr_d[iwp_q] = req_addr_q;
      iwp_d          = iwrap(iwp_q);
    end
    if (rsp) irp_d = iwrap(irp_q);

    wp_d    = wp_q;
    rp_d    = rp_q;
    fdata_d = fdata_q;
    faddr_d = faddr_q;
    if (push) begin
      fdata_d[wp_q] = instr_rdata_i;
      faddr_d[wp_q] = iaddr_q[irp_q];
      wp_d          = wp_q + PW'(1);
    end
    if (pop) rp_d = rp_q + PW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (branch_i) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= boot_addr_i & 32'hFFFF_FFFC;
      req_addr_q <= '0;
      kill_q     <= 1'b0;
      out_q      <= '0;
      discard_q  <= '0;
      cnt_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      iwp_q      <= '0;
      irp_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      kill_q     <= kill_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
      cnt_q      <= cnt_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      iwp_q      <= iwp_d;
      irp_q      <= irp_d;
    end
  end

  // Storage needs no reset: outputs are gated by the count.
  always_ff @(posedge clk_i) begin
    fdata_q <= fdata_d;
    faddr_q <= faddr_d;
    iaddr_q <= iaddr_d;
  end

`ifdef INSTR_PREFETCH_PROTO_CHK_EN
  logic        proto_err_q, proto_err_d, hold_q, hold_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic        err_rsp, err_ovf, err_addr;

  always_comb begin
    err_rsp     = instr_rvalid_i && (out_q == '0);
    err_ovf     = push && !pop && (cnt_q == CW'(DEPTH));
    err_addr    = hold_q && (!instr_req_o || (instr_addr_o != hold_addr_q));
    hold_d      = instr_req_o && !instr_gnt_i;
    hold_addr_d = instr_addr_o;
    proto_err_d = proto_err_q || err_rsp || err_ovf || err_addr;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      proto_err_q <= 1'b0;
      hold_q      <= 1'b0;
      hold_addr_q <= '0;
    end else begin
      proto_err_q <= proto_err_d;
      hold_q      <= hold_d;
      hold_addr_q <= hold_addr_d;
      if (err_rsp)  $error("instr_prefetch: rvalid with nothing outstanding");
      if (err_ovf)  $error("instr_prefetch: push into full FIFO");
      if (err_addr) $error("instr_prefetch: request changed before grant");
    end
  end

  assign proto_err_o = proto_err_q;
`else
  assign proto_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: in-order memory responder with programmable latency,
// grant control and a grant/delivery monitor; expected addresses are hand-derived.
module tb_instr_prefetch;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] boot_addr_i = '0;
  logic        fetch_en_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        fetch_valid_o;
  logic        fetch_ready_i = 1'b0;
  logic [31:0] fetch_rdata_o, fetch_addr_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_rvalid_i = 1'b0;
  logic        proto_err_o;

  instr_prefetch #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .boot_addr_i(boot_addr_i), .fetch_en_i(fetch_en_i),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i), .fetch_valid_o(fetch_valid_o),
    .fetch_ready_i(fetch_ready_i), .fetch_rdata_o(fetch_rdata_o), .fetch_addr_o(fetch_addr_o),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rdata_i(instr_rdata_i), .instr_rvalid_i(instr_rvalid_i), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {logic [31:0] a; int due;} pend_t;
  pend_t       pend[$];
  logic [31:0] iss_q[$];
  logic [31:0] dq_a[$];
  logic [31:0] dq_d[$];
  int          cyc = 0;
  int          lat = 1;
  logic        gnt_en = 1'b0;
  logic        force_rv = 1'b0;
  int          nchk = 0;
  int          nerr = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Responder and monitor act mid-cycle, away from the edge the DUT samples on.
  always @(negedge clk_i) begin
    pend_t p;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    if (force_rv) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = 32'hDEAD_BEEF;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = ~pend[0].a;
      void'(pend.pop_front());
    end
    instr_gnt_i = gnt_en;
    if (!rst_i && instr_req_o && instr_gnt_i) begin
      p.a   = instr_addr_o;
      p.due = cyc + lat;
      pend.push_back(p);
      iss_q.push_back(instr_addr_o);
    end
    if (!rst_i && fetch_valid_o && fetch_ready_i && !branch_i) begin
      dq_a.push_back(fetch_addr_o);
      dq_d.push_back(fetch_rdata_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] boot);
    rst_i       = 1'b1;
    boot_addr_i = boot;
    fetch_en_i  = 1'b0;
    branch_i    = 1'b0;
    force_rv    = 1'b0;
    repeat (3) step();
    pend.delete();
    iss_q.delete();
    dq_a.delete();
    dq_d.delete();
    rst_i = 1'b0;
  endtask

  task automatic drain();
    fetch_en_i    = 1'b0;
    fetch_ready_i = 1'b1;
    gnt_en        = 1'b1;
    repeat (12) step();
  endtask

  initial begin
    bit found;

    // Reset state, boot address with misaligned low bits
    do_reset(32'h8000_0002);
    chk("rst_req",   32'(instr_req_o),   32'd0);
    chk("rst_valid", 32'(fetch_valid_o), 32'd0);
    chk("rst_rdata", fetch_rdata_o,      32'd0);
    chk("rst_addr",  fetch_addr_o,       32'd0);
    chk("rst_perr",  32'(proto_err_o),   32'd0);

    // Streaming fetch, gnt always high, rvalid one cycle after grant
    lat = 1; gnt_en = 1'b1; fetch_ready_i = 1'b1; fetch_en_i = 1'b1;
    repeat (12) step();
    drain();
    chk("t1_niss", 32'(iss_q.size() >= 4), 32'd1);
    chk("t1_ndel", 32'(dq_a.size()), 32'(iss_q.size()));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_iss%0d", i),  iss_q[i], 32'h8000_0000 + 32'(4*i));
      chk($sformatf("t1_addr%0d", i), dq_a[i],  32'h8000_0000 + 32'(4*i));
      chk($sformatf("t1_data%0d", i), dq_d[i],  ~(32'h8000_0000 + 32'(4*i)));
    end
    chk("t1_idle_req", 32'(instr_req_o),   32'd0);
    chk("t1_empty",    32'(fetch_valid_o), 32'd0);

    // Branch while the request waits for grant
    do_reset(32'h8000_0000);
    gnt_en = 1'b0; fetch_ready_i = 1'b1; fetch_en_i = 1'b1;
    repeat (2) step();
    chk("t2_req", 32'(instr_req_o), 32'd1);
    chk("t2_addr0", instr_addr_o, 32'h8000_0000);
    branch_i = 1'b1; branch_addr_i = 32'h0000_0100;
    step();
    branch_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_hold_req%0d", i),  32'(instr_req_o), 32'd1);
      chk($sformatf("t2_hold_addr%0d", i), instr_addr_o,     32'h8000_0000);
      step();
    end
    gnt_en = 1'b1;
    repeat (10) step();
    drain();
    chk("t2_iss0",  iss_q[0], 32'h8000_0000);
    chk("t2_iss1",  iss_q[1], 32'h0000_0100);
    chk("t2_del0",  dq_a[0],  32'h0000_0100);
    chk("t2_dat0",  dq_d[0],  ~32'h0000_0100);
    chk("t2_del1",  dq_a[1],  32'h0000_0104);
    chk("t2_ndel",  32'(dq_a.size()), 32'(iss_q.size() - 1));

    // Credit exhaustion with consumer stalled, then a single pop
    do_reset(32'h0000_1000);
    lat = 1; gnt_en = 1'b1; fetch_ready_i = 1'b0; fetch_en_i = 1'b1;
    repeat (15) step();
    chk("t3_niss",  32'(iss_q.size()),   32'd4);
    chk("t3_req",   32'(instr_req_o),    32'd0);
    chk("t3_valid", 32'(fetch_valid_o),  32'd1);
    chk("t3_head",  fetch_addr_o,        32'h0000_1000);
    chk("t3_hdat",  fetch_rdata_o,       ~32'h0000_1000);
    fetch_ready_i = 1'b1;
    step();
    fetch_ready_i = 1'b0;
    repeat (10) step();
    chk("t3_niss2", 32'(iss_q.size()),   32'd5);
    chk("t3_iss4",  iss_q[4],            32'h0000_1010);
    chk("t3_ndel",  32'(dq_a.size()),    32'd1);
    chk("t3_del0",  dq_a[0],             32'h0000_1000);
    chk("t3_head2", fetch_addr_o,        32'h0000_1004);
    drain();

    // Branch in the cycle a response returns with two outstanding
    do_reset(32'h0000_4000);
    lat = 2; gnt_en = 1'b1; fetch_ready_i = 1'b1; fetch_en_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (pend.size() == 2 && pend[0].due == cyc) found = 1'b1;
    end
    chk("t4_sync", 32'(found), 32'd1);
    chk("t4_hold", 32'(instr_req_o), 32'd0);
    branch_i = 1'b1; branch_addr_i = 32'h0000_0200;
    step();
    branch_i = 1'b0;
    repeat (12) step();
    drain();
    chk("t4_iss2", iss_q[2], 32'h0000_0200);
    chk("t4_del0", dq_a[0],  32'h0000_0200);
    chk("t4_del1", dq_a[1],  32'h0000_0204);
    chk("t4_dat1", dq_d[1],  ~32'h0000_0204);
    chk("t4_ndel", 32'(dq_a.size()), 32'(iss_q.size() - 2));

    // Address wrap at the top of the 32-bit space
    do_reset(32'hFFFF_FFF8);
    lat = 1; gnt_en = 1'b1; fetch_ready_i = 1'b1; fetch_en_i = 1'b1;
    repeat (6) step();
    drain();
    chk("t5_iss0", iss_q[0], 32'hFFFF_FFF8);
    chk("t5_iss1", iss_q[1], 32'hFFFF_FFFC);
    chk("t5_iss2", iss_q[2], 32'h0000_0000);
    chk("t5_del2", dq_a[2],  32'h0000_0000);
    chk("t5_dat2", dq_d[2],  32'hFFFF_FFFF);

    // Stray response with nothing outstanding
    force_rv = 1'b1;
    step();
    force_rv = 1'b0;
    step();
    chk("t6_novalid", 32'(fetch_valid_o), 32'd0);
`ifdef INSTR_PREFETCH_PROTO_CHK_EN
    chk("t6_perr", 32'(proto_err_o), 32'd1);
    repeat (3) step();
    chk("t6_sticky", 32'(proto_err_o), 32'd1);
`else
    chk("t6_perr", 32'(proto_err_o), 32'd0);
`endif
    do_reset(32'h0);
    chk("t6_perr_rst", 32'(proto_err_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/instr_prefetch.md
Name: instr_prefetch

Overview:
Instruction-side bus initiator. Issues word fetches on the req/gnt/rvalid instruction interface that the memory model and future memory subsystem respond to. Buffers returned words in a small FIFO with their addresses and hands them to the decode stage over a valid/ready interface. On branches it redirects the fetch address, flushes the buffer and discards stale in-flight responses.

Parameters:
DEPTH, 4, FIFO entries; also the credit limit on outstanding plus buffered words (power of 2, >=2)
MAX_OUTSTANDING, 2, maximum granted requests whose rvalid has not yet returned (1..DEPTH)

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, synchronous, active-high
boot_addr_i  input  32  fetch start address, sampled during reset
fetch_en_i  input  1  allows new requests to be issued
branch_i  input  1  redirect pulse
branch_addr_i  input  32  redirect target
fetch_valid_o  output  1  FIFO head valid
fetch_ready_i  input  1  consumer accepts head
fetch_rdata_o  output  32  head instruction word
fetch_addr_o  output  32  head instruction address
instr_req_o  output  1  bus request
instr_addr_o  output  32  bus word address, bits [1:0] always 0
instr_gnt_i  input  1  bus grant
instr_rdata_i  input  32  bus read data
instr_rvalid_i  input  1  bus read data valid
proto_err_o  output  1  sticky protocol-error flag (see Optional Feature)

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset: instr_req_o=0, fetch_valid_o=0, fetch_rdata_o=0, fetch_addr_o=0, proto_err_o=0. FIFO empty, outstanding=0, discard=0. Next-fetch pc={boot_addr_i[31:2],2'b00}. Reset mid-transaction drops all state; responses after reset for pre-reset grants are not tracked.
- States: IDLE (req low), REQ (req high), HOLD (req low, credit exhausted).
  - IDLE/HOLD -> REQ when fetch_en_i=1, outstanding<MAX_OUTSTANDING and outstanding+fifo_count<DEPTH. All terms use registered values.
  - REQ -> (stays REQ or IDLE/HOLD) only on the cycle instr_gnt_i=1.
- Request stability: once instr_req_o=1, it and instr_addr_o stay constant until instr_gnt_i. This holds even if fetch_en_i drops or branch_i pulses.
- Grant (req&gnt): outstanding+1. The in-flight address FIFO (MAX_OUTSTANDING deep) pushes instr_addr_o. pc<=pc+4, wrapping modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000). req may stay high back-to-back next cycle if credit allows.
- Response (instr_rvalid_i): outstanding-1 and the in-flight address pops. If discard>0, discard-1 and the word is dropped. Otherwise {addr,rdata} is pushed to the FIFO.
- Simultaneous grant and rvalid: outstanding unchanged.
- Output: fetch_valid_o = FIFO not empty. fetch_rdata_o/fetch_addr_o show the registered head. Pop on fetch_valid_o&fetch_ready_i. A word pushed in cycle N is visible in cycle N+1; there is no bypass. Push and pop in the same cycle are allowed, including when the FIFO is full.
- Branch (branch_i=1):
  - FIFO flushed; a same-cycle pop and a same-cycle push are both ignored.
  - pc<={branch_addr_i[31:2],2'b00}.
  - discard <= outstanding value after this cycle's grant/rvalid updates.
  - If req is high and not granted this cycle, that request is marked kill. At its grant, discard+1 and pc is not advanced.
  - Next new request uses the branch target.
  - Back-to-back branches: the last one wins; discard is recomputed each time.
- Credit rule guarantees the FIFO never overflows. A response while outstanding=0 is a protocol violation.

Optional Feature:
INSTR_PREFETCH_PROTO_CHK_EN
- Defined: proto_err_o sets (sticky until reset) and $error fires when:
  - instr_rvalid_i arrives with outstanding=0;
  - a push is attempted into a full FIFO;
  - instr_addr_o changes while req is high and ungranted (self-check).
- Undefined: proto_err_o tied 0, no checks compiled.

Test Plan:
1. boot_addr_i=0x8000_0002, reset released, fetch_en_i=1, gnt always 1, rvalid 1 cycle after gnt -> requests to 0x8000_0000, 0x8000_0004, 0x8000_0008...; fetch_addr_o follows the same sequence with matching data.
2. gnt held low 5 cycles while branch_i pulses to 0x100 -> addr stays 0x8000_0000 until granted. That response is discarded; the next request and first delivered fetch_addr_o are 0x100.
3. fetch_ready_i=0, DEPTH=4 -> at most 4 grants then req stays low (HOLD). One pop -> exactly one new request issued.
4. Two outstanding, branch_i to 0x200 the same cycle one rvalid returns -> discard=1; only words from 0x200 onward appear at the output.
5. pc=0xFFFF_FFF8, continuous fetch -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
6. With INSTR_PREFETCH_PROTO_CHK_EN, rvalid injected with nothing outstanding -> proto_err_o=1 next cycle, stays 1 until rst_i.
